// File: rtl/motor_ctrl_pkg.sv
// motor_ctrl_pkg: state encoding and direction constants shared by the motor speed sequencer
package motor_ctrl_pkg;
  localparam int STATE_W = 3;
  localparam logic DIR_CW = 1'b1;
  localparam logic DIR_CCW = 1'b0;
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_RUN       = 3'd1,
    ST_BRAKE     = 3'd2,
    ST_WAIT_STOP = 3'd3,
    ST_FAULT     = 3'd4
  } state_t;
endpackage

// File: rtl/ctrl_tick_gen.sv
// ctrl_tick_gen: free-running 0..UPDATE_PERIOD-1 counter, one-cycle o_tick at terminal count
// Ports: i_clk clock, i_rst_n async active-low reset, o_tick control update pulse
module ctrl_tick_gen #(
  parameter int UPDATE_PERIOD = 1000000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_tick
);
  localparam int CW = (UPDATE_PERIOD > 1) ? $clog2(UPDATE_PERIOD) : 1;
  logic [CW-1:0] r_cnt;
  assign o_tick = (r_cnt == CW'(UPDATE_PERIOD - 1));
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_cnt <= '0;
    else r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/motor_speed_sequencer.sv
// motor_speed_sequencer: slew-limited closed-loop duty regulator with safe brake-before-reverse sequencing
// Ports: S_AXI_ACLK/S_AXI_ARESETN clock and async active-low reset; ENABLE, DIR_RQ, TARGET_RPS,
//   FAULT_CLR software controls; MOTOR_FB_RPS measured speed; MOTOR_DC, DIR_SEL_RQ motor drive;
//   AT_SPEED, FAULT, STATE status. Define MOTOR_STALL_DETECT_EN to build the stall fault logic.
module motor_speed_sequencer
  import motor_ctrl_pkg::*;
#(
  parameter int PWM_DC_WIDTH  = 8,
  parameter int FB_WIDTH      = 16,
  parameter int UPDATE_PERIOD = 1000000,
  parameter int DC_STEP       = 4,
  parameter int DEADBAND      = 1,
  parameter int ZERO_TICKS    = 2,
  parameter int STALL_TICKS   = 16
) (
  input  logic                    S_AXI_ACLK,
  input  logic                    S_AXI_ARESETN,
  input  logic                    ENABLE,
  input  logic                    DIR_RQ,
  input  logic [FB_WIDTH-1:0]     TARGET_RPS,
  input  logic [FB_WIDTH-1:0]     MOTOR_FB_RPS,
  input  logic                    FAULT_CLR,
  output logic [PWM_DC_WIDTH-1:0] MOTOR_DC,
  output logic                    DIR_SEL_RQ,
  output logic                    AT_SPEED,
  output logic                    FAULT,
  output logic [STATE_W-1:0]      STATE
);
  localparam int DW = PWM_DC_WIDTH;
  localparam int ZW = $clog2(ZERO_TICKS + 1);
  localparam logic [DW:0] DC_MAX = {1'b0, {DW{1'b1}}};
  localparam logic [DW:0] STEP = (DW + 1)'(DC_STEP);
  localparam logic signed [FB_WIDTH:0] DB = (FB_WIDTH + 1)'(DEADBAND);
  logic                       w_tick;
  state_t                     r_state, w_state_n;
  logic [DW-1:0]              r_dc, w_dc_n;
  logic                       r_dir, w_dir_n;
  logic                       r_at, w_at_n;
  logic [ZW-1:0]              r_zc, w_zc_n;
  logic signed [FB_WIDTH:0]   w_err;
  logic [DW:0]                w_dc_up, w_dc_dn, w_dc_ext;
  logic                       w_fb_zero;
  ctrl_tick_gen #(.UPDATE_PERIOD(UPDATE_PERIOD)) u_tick (
    .i_clk   (S_AXI_ACLK),
    .i_rst_n (S_AXI_ARESETN),
    .o_tick  (w_tick)
  );
  // Error and saturating duty steps are computed one bit wider so they never wrap
  assign w_err     = $signed({1'b0, TARGET_RPS}) - $signed({1'b0, MOTOR_FB_RPS});
  assign w_fb_zero = (MOTOR_FB_RPS == '0);
  assign w_dc_ext  = {1'b0, r_dc};
  assign w_dc_up   = (w_dc_ext + STEP > DC_MAX) ? DC_MAX : w_dc_ext + STEP;
  assign w_dc_dn   = (w_dc_ext < STEP) ? '0 : w_dc_ext - STEP;
  assign MOTOR_DC   = r_dc;
  assign DIR_SEL_RQ = r_dir;
  assign AT_SPEED   = r_at;
  assign STATE      = r_state;
`ifdef MOTOR_STALL_DETECT_EN
  localparam int SW = $clog2(STALL_TICKS + 1);
  logic [SW-1:0] r_sc, w_sc_n;
  logic          r_fault, w_fault_n;
  assign FAULT = r_fault;
`else
  logic w_unused;
  assign w_unused = FAULT_CLR;
  assign FAULT = 1'b0;
`endif
  always_comb begin
    w_state_n = r_state;
    w_dc_n    = r_dc;
    w_dir_n   = r_dir;
    w_at_n    = 1'b0;
    w_zc_n    = r_zc;
`ifdef MOTOR_STALL_DETECT_EN
    w_sc_n    = (r_state == ST_RUN) ? r_sc : '0;
    w_fault_n = r_fault;
`endif
    case (r_state)
      ST_IDLE: begin
        w_dc_n  = '0;
        w_dir_n = DIR_RQ;
        if (ENABLE) w_state_n = ST_RUN;
      end
      ST_RUN: begin
        if (!ENABLE || DIR_RQ != r_dir) w_state_n = ST_BRAKE;
        else if (w_tick) begin
          w_at_n = (w_err <= DB) && (w_err >= -DB);
          w_dc_n = (w_err > DB) ? w_dc_up[DW-1:0] : (w_err < -DB) ? w_dc_dn[DW-1:0] : r_dc;
`ifdef MOTOR_STALL_DETECT_EN
          w_sc_n = (w_dc_ext == DC_MAX && w_fb_zero) ? r_sc + 1'b1 : '0;
          if (w_sc_n == SW'(STALL_TICKS)) begin
            w_fault_n = 1'b1;
            w_dc_n    = '0;
            w_at_n    = 1'b0;
            w_state_n = ST_FAULT;
          end
`endif
        end else w_at_n = r_at;
      end
      ST_BRAKE: begin
        w_zc_n = '0;
        if (r_dc == '0) w_state_n = ST_WAIT_STOP;
        else if (w_tick) w_dc_n = w_dc_dn[DW-1:0];
      end
      ST_WAIT_STOP: begin
        w_dc_n = '0;
        if (w_tick) begin
          w_zc_n = w_fb_zero ? r_zc + 1'b1 : '0;
          // Direction only flips here, with the duty already held at zero
          if (w_zc_n == ZW'(ZERO_TICKS)) begin
            w_zc_n    = '0;
            w_dir_n   = DIR_RQ;
            w_state_n = ENABLE ? ST_RUN : ST_IDLE;
          end
        end
      end
`ifdef MOTOR_STALL_DETECT_EN
      ST_FAULT: begin
        w_dc_n = '0;
        if (FAULT_CLR && !ENABLE) begin
          w_fault_n = 1'b0;
          w_state_n = ST_IDLE;
        end
      end
`endif
      default: w_state_n = ST_IDLE;
    endcase
  end
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
    if (!S_AXI_ARESETN) begin
      r_state <= ST_IDLE;
      r_dc    <= '0;
      r_dir   <= DIR_CW;
      r_at    <= 1'b0;
      r_zc    <= '0;
`ifdef MOTOR_STALL_DETECT_EN
      r_sc    <= '0;
      r_fault <= 1'b0;
`endif
    end else begin
      r_state <= w_state_n;
      r_dc    <= w_dc_n;
      r_dir   <= w_dir_n;
      r_at    <= w_at_n;
      r_zc    <= w_zc_n;
`ifdef MOTOR_STALL_DETECT_EN
      r_sc    <= w_sc_n;
      r_fault <= w_fault_n;
`endif
    end
endmodule

// File: tb/tb_motor_speed_sequencer.sv
// tb_motor_speed_sequencer: directed-vector bench for motor_speed_sequencer
module tb_motor_speed_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        dir_rq = 1'b1;
  logic [15:0] target = '0;
  logic [15:0] fb = '0;
  logic        fault_clr = 1'b0;
  logic [7:0]  dc;
  logic        dir_sel;
  logic        at_speed;
  logic        fault;
  logic [2:0]  state;
  int          tcnt;
  int          n_cmp = 0;
  int          n_bad = 0;
  motor_speed_sequencer #(.UPDATE_PERIOD(10)) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .ENABLE        (enable),
    .DIR_RQ        (dir_rq),
    .TARGET_RPS    (target),
    .MOTOR_FB_RPS  (fb),
    .FAULT_CLR     (fault_clr),
    .MOTOR_DC      (dc),
    .DIR_SEL_RQ    (dir_sel),
    .AT_SPEED      (at_speed),
    .FAULT         (fault),
    .STATE         (state)
  );
  always #5 clk = ~clk;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) tcnt <= 0;
    else tcnt <= (tcnt == 9) ? 0 : tcnt + 1;
  task automatic wait_tick();
    do @(negedge clk); while (tcnt != 9);
    @(posedge clk);
    #1;
  endtask
  task automatic ticks(input int n);
    repeat (n) wait_tick();
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic expect_now(input string n, input logic [7:0] e_dc, input logic e_dir,
                            input logic [2:0] e_st, input logic e_at, input logic e_flt);
    logic bad;
    bad = 1'b0;
    n_cmp++;
    if (dc !== e_dc) bad = 1'b1;
    if (dir_sel !== e_dir) bad = 1'b1;
    if (state !== e_st) bad = 1'b1;
    if (at_speed !== e_at) bad = 1'b1;
    if (fault !== e_flt) bad = 1'b1;
    if (bad) begin
      n_bad++;
      $display("FAIL %s: got dc=%0d dir=%0d st=%0d at=%0d flt=%0d, expected dc=%0d dir=%0d st=%0d at=%0d flt=%0d",
               n, dc, dir_sel, state, at_speed, fault, e_dc, e_dir, e_st, e_at, e_flt);
    end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1);
  end
  initial begin
    #22 rst_n = 1'b1;
    cyc();
    expect_now("reset_state", 0, 1, 0, 0, 0);
    dir_rq = 1'b0;
    cyc();
    expect_now("idle_dir_follow", 0, 0, 0, 0, 0);
    dir_rq = 1'b1;
    cyc();
    target = 16'd50; fb = 16'd0; enable = 1'b1;
    cyc();
    expect_now("enter_run", 0, 1, 1, 0, 0);
    wait_tick();
    expect_now("ramp_4", 4, 1, 1, 0, 0);
    wait_tick();
    expect_now("ramp_8", 8, 1, 1, 0, 0);
    ticks(23);
    expect_now("ramp_100", 100, 1, 1, 0, 0);
    fb = 16'd50;
    wait_tick();
    expect_now("hold_at_speed", 100, 1, 1, 1, 0);
    fb = 16'd48;
    wait_tick();
    expect_now("err2_step", 104, 1, 1, 0, 0);
    fb = 16'd49;
    wait_tick();
    expect_now("deadband_edge", 104, 1, 1, 1, 0);
    target = 16'd1000; fb = 16'd0;
    ticks(37);
    expect_now("sat_252", 252, 1, 1, 0, 0);
    wait_tick();
    expect_now("sat_255", 255, 1, 1, 0, 0);
    wait_tick();
    expect_now("sat_no_wrap", 255, 1, 1, 0, 0);
    target = 16'd0; fb = 16'd500;
    wait_tick();
    expect_now("down_251", 251, 1, 1, 0, 0);
    ticks(63);
    expect_now("down_0", 0, 1, 1, 0, 0);
    wait_tick();
    expect_now("floor_0", 0, 1, 1, 0, 0);
    target = 16'd1000; fb = 16'd0;
    ticks(25);
    expect_now("rev_start_100", 100, 1, 1, 0, 0);
    dir_rq = 1'b0;
    cyc();
    expect_now("rev_brake", 100, 1, 2, 0, 0);
    ticks(24);
    expect_now("rev_brake_4", 4, 1, 2, 0, 0);
    wait_tick();
    expect_now("rev_brake_0", 0, 1, 2, 0, 0);
    cyc();
    expect_now("rev_wait_stop", 0, 1, 3, 0, 0);
    wait_tick();
    expect_now("rev_zero1", 0, 1, 3, 0, 0);
    wait_tick();
    expect_now("rev_flip_run", 0, 0, 1, 0, 0);
    wait_tick();
    expect_now("rev_ramp_resume", 4, 0, 1, 0, 0);
    ticks(9);
    expect_now("dis_start_40", 40, 0, 1, 0, 0);
    enable = 1'b0; fb = 16'd30;
    cyc();
    expect_now("dis_brake", 40, 0, 2, 0, 0);
    ticks(10);
    expect_now("dis_brake_0", 0, 0, 2, 0, 0);
    cyc();
    ticks(3);
    expect_now("dis_fb_moving", 0, 0, 3, 0, 0);
    fb = 16'd0;
    wait_tick();
    expect_now("dis_zero1", 0, 0, 3, 0, 0);
    wait_tick();
    expect_now("dis_idle", 0, 0, 0, 0, 0);
    target = 16'd1000; enable = 1'b1;
    cyc();
    ticks(25);
    expect_now("rst_pre_100", 100, 0, 1, 0, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    expect_now("async_reset", 0, 1, 0, 0, 0);
    enable = 1'b0; dir_rq = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    target = 16'd100; fb = 16'd0;
    cyc();
    enable = 1'b1;
    cyc();
    expect_now("stall_run", 0, 1, 1, 0, 0);
    ticks(64);
    expect_now("stall_255", 255, 1, 1, 0, 0);
    ticks(15);
    expect_now("stall_pre", 255, 1, 1, 0, 0);
    wait_tick();
`ifdef MOTOR_STALL_DETECT_EN
    expect_now("stall_fault", 0, 1, 4, 0, 1);
    fault_clr = 1'b1;
    cyc();
    cyc();
    expect_now("fault_hold_en", 0, 1, 4, 0, 1);
    enable = 1'b0;
    cyc();
    expect_now("fault_cleared", 0, 1, 0, 0, 0);
`else
    expect_now("no_stall", 255, 1, 1, 0, 0);
`endif
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
